core_issue_ctrl: RTL
====================

// Module: core_issue_ctrl
// PURPOSE
//  In-order issue controller between decode and the execution units (ALU, branch, mem).
//  Keeps a register scoreboard and checks RAW/WAW hazards against it and the units' raw_mask.
//  Serialises branches: nothing issues while a branch resolves. Drives the post-branch fetch flush.
// PARAMETERS
//  NUM_REGS     16  architectural registers; width of every mask (hword)
//  UNITS        3   execution units; index 0=ALU, 1=BRANCH, 2=MEM
//  FLUSH_DEPTH  2   cycles of flush after a taken branch (fetch redirect latency), >=1
// PORTS
//  clk          in   1         single clock, all state on posedge
//  rst_n        in   1         synchronous reset, active-low
//  in_valid     in   1         decoded instruction present
//  in_rs1       in   4         source reg 1
//  in_rs2       in   4         source reg 2
//  in_rd        in   4         destination reg
//  in_use_rs1   in   1         rs1 is read
//  in_use_rs2   in   1         rs2 is read
//  in_wb        in   1         instruction writes rd
//  in_unit      in   2         target unit index (<UNITS)
//  in_ready     out  1         instruction accepted this cycle (issue)
//  unit_start   out  UNITS     one-hot start pulse to target unit, same cycle as in_ready
//  unit_stall   in   UNITS     per-unit busy; no issue to a stalled unit
//  raw_mask     in   16        OR of units' in-flight destination masks
//  wb_ready     in   1         writeback commit this cycle
//  wb_rd        in   4         register being committed
//  branch       in   1         branch unit redirect (taken branch or reset vector)
//  flush        out  1         discard fetched/decoded instructions
//  pending      out  16        scoreboard, bit r = write to r outstanding
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=FLUSH, cnt=FLUSH_DEPTH-1, pending=0. flush=1; in_ready=0, unit_start=0.
//  busy = pending | raw_mask.
//  hazard = (in_use_rs1 & busy[in_rs1]) | (in_use_rs2 & busy[in_rs2]) | (in_wb & pending[in_rd]).
//  issue = in_valid & state==RUN & !branch & !hazard & !unit_stall[in_unit]. Combinational.
//  in_ready=issue; unit_start=issue<<in_unit; not valid -> no start. Zero-cycle decision, no buffering.
//  States:
//   RUN:     issue to BRANCH unit -> BR_WAIT; branch=1 -> FLUSH; else stay.
//   BR_WAIT: no issue (branch resolves in this cycle). branch=1 -> FLUSH, else -> RUN.
//   FLUSH:   flush=1, no issue. cnt decrements. cnt==0 & !branch -> RUN.
//  branch=1 in any state (re)enters FLUSH with cnt=FLUSH_DEPTH-1. It has priority over every transition.
//  flush is registered: flush=(state==FLUSH). Asserted from the cycle after branch is sampled.
//  Scoreboard, per cycle:
//   issue & in_wb sets pending[in_rd]; wb_ready clears pending[wb_rd].
//   Set and clear of the same bit in one cycle -> set wins.
//   wb_ready on a non-pending register is ignored (no error).
//   Flush does NOT clear pending, because in-flight writes still commit.
//  A source whose pending bit clears this cycle is still a hazard this cycle (no bypass). Issue happens next cycle.
//  Reset mid-FLUSH or BR_WAIT: next cycle is the reset state above. pending is dropped.
//  in_unit>=UNITS: treated as hazard, never issued.
// STRUCTURE
//  uarch package: unit index constants (UNIT_ALU/BRANCH/MEM), issue_state enum {RUN,BR_WAIT,FLUSH}, reg index type.
//  Sub-module core_scoreboard: pending vector set/clear, exposes pending and busy.
//  FSM, hazard and start decode stay in core_issue_ctrl.
// TESTING
//  1 Reset, in_valid=1 ALU, branch=1 first cycle -> flush=1 for 2 cycles after branch drops, then in_ready=1, unit_start=3'b001.
//  2 Issue ALU rd=5 wb, then rs1=5 -> held. wb_ready,wb_rd=5 at t -> issue at t+1, pending[5]=0 at t+1.
//  3 raw_mask=16'h0008, rs2=3 used -> in_ready=0. raw_mask=0 -> same-cycle issue.
//  4 Branch issue, branch=0 next -> one dead cycle (BR_WAIT), then issue resumes.
//  5 Branch issue, branch=1 next -> flush 2 cycles, no starts, pending preserved.
//  6 Same-cycle wb_ready rd=7 and issue wb rd=7 -> pending[7]=1. rst_n=0 during FLUSH -> pending=0, flush=1.

Source files
------------

// File: rtl/core_issue_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// core_issue_ctrl_pkg
//   Shared micro-architecture definitions for the in-order issue controller:
//   - register-file and unit sizing
//   - unit index constants
//   - the issue FSM state encoding
//   - the register index type
//   - a helper that expands a register index into a one-hot register mask
// ----------------------------------------------------------------------------
package core_issue_ctrl_pkg;

  localparam int NUM_REGS          = 16;  // architectural registers = mask width
  localparam int REG_W             = 4;   // width of a register index
  localparam int UNITS             = 3;   // execution units
  localparam int UNIT_W            = 2;   // width of a unit index
  localparam int FLUSH_DEPTH_DEF   = 2;   // fetch redirect latency in cycles

  localparam logic [UNIT_W-1:0] UNIT_ALU    = 2'd0;
  localparam logic [UNIT_W-1:0] UNIT_BRANCH = 2'd1;
  localparam logic [UNIT_W-1:0] UNIT_MEM    = 2'd2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } issue_state_t;

  typedef logic [REG_W-1:0] reg_idx_t;

  // One-hot register mask, optionally gated off
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en, input reg_idx_t r);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (en) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/core_issue_ctrl_scoreboard.sv
// ----------------------------------------------------------------------------
// core_scoreboard
//   Register scoreboard: one pending bit per architectural register, set when
//   an instruction that writes that register issues and cleared when its
//   writeback commits. A set and a clear of the same bit in one cycle leave
//   the bit set (the new writer is still outstanding).
// Ports
//   clk       in   clock
//   rst_n     in   synchronous active-low reset, clears all pending bits
//   set_en    in   issue of a register-writing instruction this cycle
//   set_rd    in   destination register of that instruction
//   clr_en    in   writeback commit this cycle
//   clr_rd    in   register being committed
//   raw_mask  in   destinations still in flight inside the execution units
//   pending   out  registered scoreboard
//   busy      out  pending | raw_mask (sources that may not be read yet)
// ----------------------------------------------------------------------------
module core_scoreboard
  import core_issue_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  reg_idx_t            set_rd,
  input  logic                clr_en,
  input  reg_idx_t            clr_rd,
  input  logic [NUM_REGS-1:0] raw_mask,
  output logic [NUM_REGS-1:0] pending,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] pending_reg;
  logic [NUM_REGS-1:0] pending_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_en && (set_rd == REG_W'(gi));
      assign clr_hit = clr_en && (clr_rd == REG_W'(gi));
      // Set dominates clear; clearing an idle bit is harmless.
      assign pending_next[gi] = set_hit | (pending_reg[gi] & ~clr_hit);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) pending_reg <= '0;
    else        pending_reg <= pending_next;
  end

  assign pending = pending_reg;
  assign busy    = pending_reg | raw_mask;

endmodule

// File: rtl/core_issue_ctrl.sv
// ----------------------------------------------------------------------------
// core_issue_ctrl
//   In-order, zero-buffer issue controller between decode and the ALU, branch
//   and memory units. An instruction issues in the cycle it is presented if
//   the FSM is in RUN, no redirect is signalled, it has no RAW/WAW hazard
//   against the scoreboard / in-flight mask, and its unit is not stalled.
//   A branch issue blocks issue for one cycle while it resolves; a redirect
//   holds flush for FLUSH_DEPTH cycles.
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   in_valid, in_rs1, in_rs2,
//   in_rd, in_use_rs1,
//   in_use_rs2, in_wb, in_unit   decoded instruction
//   in_ready                     instruction accepted (issued) this cycle
//   unit_start                   one-hot start to the target unit
//   unit_stall                   per-unit busy
//   raw_mask                     in-flight destination mask from the units
//   wb_ready, wb_rd              writeback commit
//   branch                       redirect from the branch unit
//   flush                        discard fetched/decoded instructions
//   pending                      scoreboard contents
// ----------------------------------------------------------------------------
module core_issue_ctrl
  import core_issue_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  reg_idx_t            in_rs1,
  input  reg_idx_t            in_rs2,
  input  reg_idx_t            in_rd,
  input  logic                in_use_rs1,
  input  logic                in_use_rs2,
  input  logic                in_wb,
  input  logic [UNIT_W-1:0]   in_unit,
  output logic                in_ready,
  output logic [UNITS-1:0]    unit_start,
  input  logic [UNITS-1:0]    unit_stall,
  input  logic [NUM_REGS-1:0] raw_mask,
  input  logic                wb_ready,
  input  reg_idx_t            wb_rd,
  input  logic                branch,
  output logic                flush,
  output logic [NUM_REGS-1:0] pending
);

  localparam int CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_DEPTH - 1);

  issue_state_t        state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [NUM_REGS-1:0] busy;
  logic [UNITS-1:0]    unit_hit;
  logic                unit_ok;
  logic                unit_blocked;
  logic                hazard;
  logic                issue;

  // Decode the target unit once; an index past the last unit matches nothing
  // and is therefore never issued.
  genvar gi;
  generate
    for (gi = 0; gi < UNITS; gi++) begin : g_unit
      assign unit_hit[gi] = (in_unit == UNIT_W'(gi));
    end
  endgenerate

  assign unit_ok      = |unit_hit;
  assign unit_blocked = |(unit_hit & unit_stall);

  // Sources check against in-flight results too; the destination only needs
  // the scoreboard (WAW). A bit clearing this cycle still blocks: no bypass.
  assign hazard = (in_use_rs1 & busy[in_rs1])
                | (in_use_rs2 & busy[in_rs2])
                | (in_wb & pending[in_rd])
                | ~unit_ok;

  assign issue = in_valid && (state_reg == RUN) && !branch && !hazard && !unit_blocked;

  assign in_ready   = issue;
  assign unit_start = issue ? unit_hit : '0;
  assign flush      = (state_reg == FLUSH);

  core_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue & in_wb),
    .set_rd   (in_rd),
    .clr_en   (wb_ready),
    .clr_rd   (wb_rd),
    .raw_mask (raw_mask),
    .pending  (pending),
    .busy     (busy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= FLUSH;
      cnt_reg   <= CNT_INIT;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (branch) begin
      // A redirect restarts the flush window from any state.
      state_next = FLUSH;
      cnt_next   = CNT_INIT;
    end else begin
      case (state_reg)
        RUN: begin
          if (issue && (in_unit == UNIT_BRANCH)) state_next = BR_WAIT;
        end
        BR_WAIT: begin
          state_next = RUN;
        end
        FLUSH: begin
          if (cnt_reg == '0) state_next = RUN;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        default: begin
          state_next = FLUSH;
          cnt_next   = CNT_INIT;
        end
      endcase
    end
  end

endmodule
